dmem_mmio: RTL and testbench

- Data-side memory subsystem directly downstream of the single-cycle ARM core.
- Consumes the core's data address (ALUResult), WriteData and MemWrite, and returns ReadData in the same cycle.
- Decodes a small address map: word RAM, LED output register, synchronized switch inputs, and a prescaled 32-bit timer with compare flag and interrupt line.
- Replaces the bare data RAM at the top level so Practica programs can drive board I/O with plain LDR/STR.

---
 rtl/dmem_mmio.sv | 129 ++++++++++++
 tb/tb_dmem_mmio.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_mmio.sv
// Data-side memory subsystem for the single-cycle core: word RAM plus LED, switch and timer registers.
// Loads are combinational from addr; stores commit on the rising edge when we is high.
module dmem_mmio #(
  parameter int RAM_WORDS = 64,
  parameter int LED_W     = 10,
  parameter int SW_W      = 10,
  parameter int PRESC_DIV = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  input  logic              we,
  output logic [31:0]       rdata,
  input  logic [SW_W-1:0]   sw,
  output logic [LED_W-1:0]  led,
  output logic              irq
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESC_DIV - 1);

  typedef enum logic [2:0] {
    SEL_NONE, SEL_RAM, SEL_LED, SEL_SW, SEL_TCTRL, SEL_TCOUNT, SEL_TCMP, SEL_TSTAT
  } sel_e;

  logic [29:0]      word;
  sel_e             sel;
  logic [31:0]      mem [RAM_WORDS];
  logic [LED_W-1:0] led_q;
  logic [SW_W-1:0]  sw_meta, sw_sync;
  logic             en, autoreload, match;
  logic [31:0]      tcount, tcmp;
  logic [PW-1:0]    presc;
  logic             tick, hit;
  logic             unused_addr_bits;

  // Byte offset within a word is ignored everywhere, including the peripheral compare.
  assign word             = addr[31:2];
  assign unused_addr_bits = ^addr[1:0];

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    sel = SEL_NONE;
    if (word < 30'(RAM_WORDS)) begin
      sel = SEL_RAM;
    end else begin
      case (word)
        30'h100: sel = SEL_LED;
        30'h101: sel = SEL_SW;
        30'h102: sel = SEL_TCTRL;
        30'h103: sel = SEL_TCOUNT;
        30'h104: sel = SEL_TCMP;
        30'h105: sel = SEL_TSTAT;
        default: sel = SEL_NONE;
      endcase
    end
  end

  always_comb begin
    rdata = 32'h0;
    case (sel)
      SEL_RAM:    rdata = mem[addr[AW+1:2]];
      SEL_LED:    rdata = 32'(led_q);
      SEL_SW:     rdata = 32'(sw_sync);
      SEL_TCTRL:  rdata = {30'h0, autoreload, en};
      SEL_TCOUNT: rdata = tcount;
      SEL_TCMP:   rdata = tcmp;
      SEL_TSTAT:  rdata = {31'h0, match};
      default:    rdata = 32'h0;
    endcase
  end

  // NOTE: the RAM array has no reset so it maps onto block/distributed RAM and survives reset.
  always_ff @(posedge clk) begin
    if (we && sel == SEL_RAM) mem[addr[AW+1:2]] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q   <= '0;
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      if (we && sel == SEL_LED) led_q <= wdata[LED_W-1:0];
      sw_meta <= sw;
      sw_sync <= sw_meta;
    end
  end

  // The tick is decided from the pre-edge EN, so disabling on a tick edge still lets that tick land.
  assign tick = en && (presc == PRESC_MAX);
  assign hit  = tick && (tcount == tcmp);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc      <= '0;
      en         <= 1'b0;
      autoreload <= 1'b0;
      tcount     <= 32'h0;
      tcmp       <= 32'hFFFF_FFFF;
      match      <= 1'b0;
    end else begin
      presc <= (!en || tick) ? '0 : presc + 1'b1;

      if (we && sel == SEL_TCTRL) begin
        en         <= wdata[0];
        autoreload <= wdata[1];
      end

      if (we && sel == SEL_TCMP) tcmp <= wdata;

      // A CPU store to TCOUNT overrides the tick increment in the same cycle.
      if (we && sel == SEL_TCOUNT) tcount <= wdata;
      else if (hit)                tcount <= autoreload ? 32'h0 : tcount + 32'h1;
      else if (tick)               tcount <= tcount + 32'h1;

      // Setting the flag wins over a simultaneous write-1-to-clear.
      if (hit)                                       match <= 1'b1;
      else if (we && sel == SEL_TSTAT && wdata[0])   match <= 1'b0;
    end
  end

  assign led = led_q;
  assign irq = match;

endmodule

// File: tb/tb_dmem_mmio.sv
// Self-checking bench for dmem_mmio: table-driven RAM/LED vectors plus timer, switch and reset sequences.
// Inputs change 1 time unit after a rising edge; outputs are compared well before the next edge.
module tb_dmem_mmio;

  localparam logic [31:0] A_LED    = 32'h400;
  localparam logic [31:0] A_SW     = 32'h404;
  localparam logic [31:0] A_TCTRL  = 32'h408;
  localparam logic [31:0] A_TCOUNT = 32'h40C;
  localparam logic [31:0] A_TCMP   = 32'h410;
  localparam logic [31:0] A_TSTAT  = 32'h414;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr, wdata, rdata;
  logic        we;
  logic [9:0]  sw, led;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q [$];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs [12];

  dmem_mmio #(.RAM_WORDS(64), .LED_W(10), .SW_W(10), .PRESC_DIV(4)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we),
    .rdata(rdata), .sw(sw), .led(led), .irq(irq)
  );

  always #50 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    exp_q.push_back(exp);
    addr = a; we = 1'b0;
    #1;
    check(name, rdata, exp_q.pop_front());
  endtask

  initial begin
    vecs[0]  = '{1'b1, 32'h010, 32'hDEAD_BEEF, 32'h0,          "st_ram10"};
    vecs[1]  = '{1'b1, 32'h0FC, 32'hCAFE_F00D, 32'h0,          "st_ramfc"};
    vecs[2]  = '{1'b0, 32'h010, 32'h0,         32'hDEAD_BEEF, "ld_ram10"};
    vecs[3]  = '{1'b0, 32'h0FC, 32'h0,         32'hCAFE_F00D, "ld_ramfc"};
    vecs[4]  = '{1'b0, 32'h100, 32'h0,         32'h0,          "ld_100"};
    vecs[5]  = '{1'b1, 32'h800, 32'h1234_5678, 32'h0,          "st_800"};
    vecs[6]  = '{1'b0, 32'h800, 32'h0,         32'h0,          "ld_800"};
    vecs[7]  = '{1'b1, A_LED,   32'hFFFF_FFFF, 32'h0,          "st_led"};
    vecs[8]  = '{1'b0, A_LED,   32'h0,         32'h0000_03FF, "ld_led"};
    vecs[9]  = '{1'b0, 32'h013, 32'h0,         32'hDEAD_BEEF, "ld_ram_unaligned"};
    vecs[10] = '{1'b0, A_TCTRL, 32'h0,         32'h0,          "ld_tctrl"};
    vecs[11] = '{1'b0, 32'h41C, 32'h0,         32'h0,          "ld_unmapped"};

    reset = 1'b1; addr = 32'h0; wdata = 32'h0; we = 1'b0; sw = '0;
    #1;
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_led", 32'(led), 32'h0);
    rd_check("rst_tcmp", A_TCMP, 32'hFFFF_FFFF);
    rd_check("rst_tcount", A_TCOUNT, 32'h0);
    rd_check("rst_tstat", A_TSTAT, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].we) wr(vecs[i].addr, vecs[i].wdata);
      else            rd_check(vecs[i].name, vecs[i].addr, vecs[i].exp);
    end
    check("led_port", 32'(led), 32'h3FF);

    // Same-cycle read during a store returns the old word.
    wr(32'h020, 32'hA5A5_0001);
    addr = 32'h020; wdata = 32'h5A5A_0002; we = 1'b1;
    #1 check("rd_old_during_wr", rdata, 32'hA5A5_0001);
    @(posedge clk); #1 we = 1'b0;
    rd_check("rd_new_after_wr", 32'h020, 32'h5A5A_0002);

    // Switch synchronizer: visible on the 2nd edge, not the 1st.
    sw = 10'h155;
    rd_check("sw_edge0", A_SW, 32'h0);
    idle(1);
    rd_check("sw_edge1", A_SW, 32'h0);
    idle(1);
    rd_check("sw_edge2", A_SW, 32'h155);

    // Free-running timer: tick every 4 clocks after enable.
    wr(A_TCMP, 32'd3);
    wr(A_TCTRL, 32'h1);
    rd_check("fr_e0", A_TCOUNT, 32'd0);
    idle(3);
    rd_check("fr_e3", A_TCOUNT, 32'd0);
    idle(1);
    rd_check("fr_e4", A_TCOUNT, 32'd1);
    idle(4);
    rd_check("fr_e8", A_TCOUNT, 32'd2);
    idle(4);
    rd_check("fr_e12", A_TCOUNT, 32'd3);
    check("fr_irq_before", 32'(irq), 32'h0);
    idle(4);
    rd_check("fr_e16", A_TCOUNT, 32'd4);
    check("fr_irq_match", 32'(irq), 32'h1);
    wr(A_TSTAT, 32'h1);
    check("fr_irq_clear", 32'(irq), 32'h0);
    wr(A_TCTRL, 32'h0);

    // Autoreload: 0,1,2,0,1,2 with match on the first wrap.
    wr(A_TCOUNT, 32'h0);
    wr(A_TCMP, 32'd2);
    wr(A_TCTRL, 32'h3);
    for (int i = 0; i < 6; i++) begin
      rd_check($sformatf("ar_count%0d", i), A_TCOUNT, 32'(i % 3));
      check($sformatf("ar_irq%0d", i), 32'(irq), (i == 3) ? 32'h1 : 32'h0);
      if (i == 3) begin
        wr(A_TSTAT, 32'h1);
        idle(3);
      end else if (i < 5) begin
        idle(4);
      end
    end
    idle(3);
    wr(A_TSTAT, 32'h1);
    check("ar_set_beats_clear", 32'(irq), 32'h1);
    rd_check("ar_wrap_count", A_TCOUNT, 32'h0);

    // CPU store to TCOUNT on a tick edge wins over the increment.
    idle(3);
    wr(A_TCOUNT, 32'h100);
    rd_check("coll_tcount", A_TCOUNT, 32'h100);

    // Wrap from all-ones without a match.
    wr(A_TSTAT, 32'h1);
    wr(A_TCMP, 32'd5);
    wr(A_TCOUNT, 32'hFFFF_FFFF);
    idle(1);
    rd_check("wrap_count", A_TCOUNT, 32'h0);
    check("wrap_irq", 32'(irq), 32'h0);

    // Disabling on a tick edge still applies that tick, then the timer stops.
    idle(3);
    wr(A_TCTRL, 32'h0);
    rd_check("dis_tick_applied", A_TCOUNT, 32'd1);
    idle(8);
    rd_check("dis_held", A_TCOUNT, 32'd1);

    // Async reset between edges clears state at once; RAM survives.
    wr(A_TCMP, 32'd1);
    wr(A_TCTRL, 32'h1);
    idle(4);
    check("pre_rst_irq", 32'(irq), 32'h1);
    rd_check("pre_rst_count", A_TCOUNT, 32'd2);
    #10 reset = 1'b1;
    #1;
    check("async_irq", 32'(irq), 32'h0);
    check("async_led", 32'(led), 32'h0);
    rd_check("async_tcount", A_TCOUNT, 32'h0);
    rd_check("async_tcmp", A_TCMP, 32'hFFFF_FFFF);
    rd_check("ram_retained", 32'h010, 32'hDEAD_BEEF);
    idle(1);
    reset = 1'b0;
    idle(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
